// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for the rv32im core: sequences fetch/decode/execute/memory/writeback
// with valid/ready handshakes to a shared memory port and an iterative mul/div unit.
package mc_control_pkg;
  typedef enum logic [1:0] {
    ALU_SRCA_RD1   = 2'd0,
    ALU_SRCA_PC    = 2'd1,
    ALU_SRCA_OLDPC = 2'd2
  } AluSrcA_t;

  typedef enum logic [1:0] {
    ALU_SRCB_RD2     = 2'd0,
    ALU_SRCB_IMM_EXT = 2'd1,
    ALU_SRCB_4       = 2'd2
  } AluSrcB_t;

  typedef enum logic [2:0] {
    ALU_OP_ADD         = 3'd0,
    ALU_OP_ARITH_LOGIC = 3'd1,
    ALU_OP_BRANCH      = 3'd2,
    ALU_OP_LUI         = 3'd3,
    ALU_OP_AUIPC       = 3'd4
  } AluOp_t;

  typedef enum logic [2:0] {
    RESULT_SRC_ALURESULT = 3'd0,
    RESULT_SRC_READDATA  = 3'd1,
    RESULT_SRC_PCPLUS4   = 3'd2,
    RESULT_SRC_MULDIV    = 3'd3,
    RESULT_SRC_CSRDATA   = 3'd4
  } ResultSrc_t;

  typedef enum logic [2:0] {
    IMMSRC_I_TYPE = 3'd0,
    IMMSRC_S_TYPE = 3'd1,
    IMMSRC_B_TYPE = 3'd2,
    IMMSRC_U_TYPE = 3'd3,
    IMMSRC_J_TYPE = 3'd4,
    IMMSRC_R_TYPE = 3'd5
  } ImmSrc_t;
endpackage

module mc_control_fsm
  import mc_control_pkg::*;
#(
  parameter bit MULDIV_EN    = 1'b1,
  parameter bit CSR_EN       = 1'b1,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       funct7b1,
  input  logic       mem_ready,
  input  logic       md_ready,
  output logic       mem_valid,
  output logic       md_valid,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       Branch,
  output logic       RegWrite,
  output logic       MemWrite,
  output AluSrcA_t   AluSrcA,
  output AluSrcB_t   AluSrcB,
  output AluOp_t     AluOp,
  output ResultSrc_t ResultSrc,
  output ImmSrc_t    ImmSrc,
  output logic       icycle_inc,
  output logic       illegal_instr,
  output logic       halted
);

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
  localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMREAD  = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWRITE = 5'd5,
    S_EXEC_R   = 5'd6,
    S_EXEC_I   = 5'd7,
    S_LUI      = 5'd8,
    S_AUIPC    = 5'd9,
    S_ALUWB    = 5'd10,
    S_JAL      = 5'd11,
    S_JALR     = 5'd12,
    S_BRANCH   = 5'd13,
    S_MULDIV   = 5'd14,
    S_CSR      = 5'd15,
    S_ILLEGAL  = 5'd16,
    S_HALT     = 5'd17
  } state_t;

  state_t state_r;
  state_t next_state_s;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; handshake states only advance on their own ready
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_FETCH: begin
        if (mem_ready) next_state_s = S_DECODE;
        else           next_state_s = S_FETCH;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: next_state_s = S_MEMADR;
          OP_RTYPE: begin
            if (!funct7b1)      next_state_s = S_EXEC_R;
            else if (MULDIV_EN) next_state_s = S_MULDIV;
            else                next_state_s = S_ILLEGAL;
          end
          OP_ITYPE:  next_state_s = S_EXEC_I;
          OP_JAL:    next_state_s = S_JAL;
          OP_JALR:   next_state_s = S_JALR;
          OP_BRANCH: next_state_s = S_BRANCH;
          OP_LUI:    next_state_s = S_LUI;
          OP_AUIPC:  next_state_s = S_AUIPC;
          OP_SYSTEM: begin
            if (CSR_EN) next_state_s = S_CSR;
            else        next_state_s = S_ILLEGAL;
          end
          default:   next_state_s = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LOAD) next_state_s = S_MEMREAD;
        else               next_state_s = S_MEMWRITE;
      end
      S_MEMREAD: begin
        if (mem_ready) next_state_s = S_MEMWB;
        else           next_state_s = S_MEMREAD;
      end
      S_MEMWRITE: begin
        if (mem_ready) next_state_s = S_FETCH;
        else           next_state_s = S_MEMWRITE;
      end
      S_MULDIV: begin
        if (md_ready) next_state_s = S_FETCH;
        else          next_state_s = S_MULDIV;
      end
      S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC: next_state_s = S_ALUWB;
      S_MEMWB, S_ALUWB, S_JAL, S_JALR, S_BRANCH, S_CSR: next_state_s = S_FETCH;
      S_ILLEGAL: begin
        if (ILLEGAL_HALT) next_state_s = S_HALT;
        else              next_state_s = S_FETCH;
      end
      S_HALT:  next_state_s = S_HALT;
      default: next_state_s = S_FETCH;
    endcase
  end

  // Output decode; reset forces every request low without waiting for a clock
  always_comb begin
    mem_valid     = 1'b0;
    md_valid      = 1'b0;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCUpdate      = 1'b0;
    Branch        = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    AluSrcA       = ALU_SRCA_RD1;
    AluSrcB       = ALU_SRCB_RD2;
    AluOp         = ALU_OP_ADD;
    ResultSrc     = RESULT_SRC_ALURESULT;
    icycle_inc    = 1'b0;
    illegal_instr = 1'b0;
    halted        = 1'b0;
    if (reset) begin
      mem_valid = 1'b0;
      md_valid  = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_valid = 1'b1;
          if (mem_ready) begin
            IRWrite  = 1'b1;
            PCUpdate = 1'b1;
            AluSrcA  = ALU_SRCA_PC;
            AluSrcB  = ALU_SRCB_4;
          end else begin
            IRWrite  = 1'b0;
          end
        end
        S_DECODE: begin
          AluSrcA = ALU_SRCA_OLDPC;
          AluSrcB = ALU_SRCB_IMM_EXT;
        end
        S_MEMADR: AluSrcB = ALU_SRCB_IMM_EXT;
        S_MEMREAD: begin
          mem_valid = 1'b1;
          AdrSrc    = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc  = RESULT_SRC_READDATA;
          RegWrite   = 1'b1;
          icycle_inc = 1'b1;
        end
        S_MEMWRITE: begin
          mem_valid = 1'b1;
          MemWrite  = 1'b1;
          AdrSrc    = 1'b1;
          if (mem_ready) icycle_inc = 1'b1;
          else           icycle_inc = 1'b0;
        end
        S_EXEC_R: AluOp = ALU_OP_ARITH_LOGIC;
        S_EXEC_I: begin
          AluOp   = ALU_OP_ARITH_LOGIC;
          AluSrcB = ALU_SRCB_IMM_EXT;
        end
        S_LUI: begin
          AluOp   = ALU_OP_LUI;
          AluSrcB = ALU_SRCB_IMM_EXT;
        end
        S_AUIPC: begin
          AluOp   = ALU_OP_AUIPC;
          AluSrcA = ALU_SRCA_OLDPC;
          AluSrcB = ALU_SRCB_IMM_EXT;
        end
        S_ALUWB: begin
          RegWrite   = 1'b1;
          icycle_inc = 1'b1;
        end
        // Jump target was already formed in DECODE and sits in the ALU result register
        S_JAL: begin
          PCUpdate   = 1'b1;
          ResultSrc  = RESULT_SRC_PCPLUS4;
          RegWrite   = 1'b1;
          icycle_inc = 1'b1;
        end
        S_JALR: begin
          AluSrcB    = ALU_SRCB_IMM_EXT;
          PCUpdate   = 1'b1;
          ResultSrc  = RESULT_SRC_PCPLUS4;
          RegWrite   = 1'b1;
          icycle_inc = 1'b1;
        end
        S_BRANCH: begin
          AluOp      = ALU_OP_BRANCH;
          Branch     = 1'b1;
          icycle_inc = 1'b1;
        end
        S_MULDIV: begin
          md_valid = 1'b1;
          if (md_ready) begin
            ResultSrc  = RESULT_SRC_MULDIV;
            RegWrite   = 1'b1;
            icycle_inc = 1'b1;
          end else begin
            RegWrite   = 1'b0;
          end
        end
        S_CSR: begin
          ResultSrc  = RESULT_SRC_CSRDATA;
          RegWrite   = 1'b1;
          icycle_inc = 1'b1;
        end
        S_ILLEGAL: illegal_instr = 1'b1;
        S_HALT:    halted        = 1'b1;
        default:   halted        = 1'b0;
      endcase
    end
  end

  // Immediate format decoded straight from the opcode
  always_comb begin
    ImmSrc = IMMSRC_R_TYPE;
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR, OP_SYSTEM: ImmSrc = IMMSRC_I_TYPE;
      OP_STORE:                              ImmSrc = IMMSRC_S_TYPE;
      OP_BRANCH:                             ImmSrc = IMMSRC_B_TYPE;
      OP_LUI, OP_AUIPC:                      ImmSrc = IMMSRC_U_TYPE;
      OP_JAL:                                ImmSrc = IMMSRC_J_TYPE;
      default:                               ImmSrc = IMMSRC_R_TYPE;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-cycle vector table plus hand-written handshake,
// illegal-instruction and reset-abort sequences on three parameterisations.
module tb_mc_control_fsm;
  import mc_control_pkg::*;

  localparam logic [10:0] F_MV   = 11'b100_0000_0000;
  localparam logic [10:0] F_MDV  = 11'b010_0000_0000;
  localparam logic [10:0] F_ADR  = 11'b001_0000_0000;
  localparam logic [10:0] F_IRW  = 11'b000_1000_0000;
  localparam logic [10:0] F_PCU  = 11'b000_0100_0000;
  localparam logic [10:0] F_BR   = 11'b000_0010_0000;
  localparam logic [10:0] F_RW   = 11'b000_0001_0000;
  localparam logic [10:0] F_MW   = 11'b000_0000_1000;
  localparam logic [10:0] F_IC   = 11'b000_0000_0100;
  localparam logic [10:0] F_ILL  = 11'b000_0000_0010;
  localparam logic [10:0] F_HALT = 11'b000_0000_0001;
  localparam logic [10:0] F_NONE = 11'b000_0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_RTYPE  = 7'b011_0011;
  localparam logic [6:0] OP_ITYPE  = 7'b001_0011;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

  logic clk, reset, funct7b1, mem_ready, md_ready;
  logic [6:0] op;

  wire [10:0] fl0, fl1, fl2;
  AluSrcA_t a0, a1, a2;
  AluSrcB_t b0, b1, b2;
  AluOp_t o0, o1, o2;
  ResultSrc_t r0, r1, r2;
  ImmSrc_t i0, i1, i2;

  mc_control_fsm dut (
    .clk(clk), .reset(reset), .op(op), .funct7b1(funct7b1),
    .mem_ready(mem_ready), .md_ready(md_ready),
    .mem_valid(fl0[10]), .md_valid(fl0[9]), .AdrSrc(fl0[8]), .IRWrite(fl0[7]),
    .PCUpdate(fl0[6]), .Branch(fl0[5]), .RegWrite(fl0[4]), .MemWrite(fl0[3]),
    .AluSrcA(a0), .AluSrcB(b0), .AluOp(o0), .ResultSrc(r0), .ImmSrc(i0),
    .icycle_inc(fl0[2]), .illegal_instr(fl0[1]), .halted(fl0[0])
  );

  mc_control_fsm #(.MULDIV_EN(1'b0)) dut_nomd (
    .clk(clk), .reset(reset), .op(op), .funct7b1(funct7b1),
    .mem_ready(mem_ready), .md_ready(md_ready),
    .mem_valid(fl1[10]), .md_valid(fl1[9]), .AdrSrc(fl1[8]), .IRWrite(fl1[7]),
    .PCUpdate(fl1[6]), .Branch(fl1[5]), .RegWrite(fl1[4]), .MemWrite(fl1[3]),
    .AluSrcA(a1), .AluSrcB(b1), .AluOp(o1), .ResultSrc(r1), .ImmSrc(i1),
    .icycle_inc(fl1[2]), .illegal_instr(fl1[1]), .halted(fl1[0])
  );

  mc_control_fsm #(.ILLEGAL_HALT(1'b0)) dut_ilf (
    .clk(clk), .reset(reset), .op(op), .funct7b1(funct7b1),
    .mem_ready(mem_ready), .md_ready(md_ready),
    .mem_valid(fl2[10]), .md_valid(fl2[9]), .AdrSrc(fl2[8]), .IRWrite(fl2[7]),
    .PCUpdate(fl2[6]), .Branch(fl2[5]), .RegWrite(fl2[4]), .MemWrite(fl2[3]),
    .AluSrcA(a2), .AluSrcB(b2), .AluOp(o2), .ResultSrc(r2), .ImmSrc(i2),
    .icycle_inc(fl2[2]), .illegal_instr(fl2[1]), .halted(fl2[0])
  );

  typedef struct {
    logic [6:0]  op;
    logic        mr;
    logic [10:0] fl;
    AluSrcA_t    a;
    AluSrcB_t    b;
    AluOp_t      aop;
    ResultSrc_t  rs;
    ImmSrc_t     imm;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [12:0] enc(input AluSrcA_t a, input AluSrcB_t b, input AluOp_t o,
                                      input ResultSrc_t r, input ImmSrc_t i);
    return {a, b, o, r, i};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("reset_outputs_low", 32'(fl0), 32'(F_NONE));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic add(input logic [6:0] o, input logic mr, input logic [10:0] f, input AluSrcA_t a,
                     input AluSrcB_t b, input AluOp_t ao, input ResultSrc_t rs, input ImmSrc_t im);
    vec_t v;
    v.op = o; v.mr = mr; v.fl = f; v.a = a; v.b = b; v.aop = ao; v.rs = rs; v.imm = im;
    vecs.push_back(v);
  endtask

  // FETCH with an immediate ready, then DECODE
  task automatic add_fd(input logic [6:0] o, input ImmSrc_t im);
    add(o, 1'b1, F_MV | F_IRW | F_PCU, ALU_SRCA_PC, ALU_SRCB_4, ALU_OP_ADD, RESULT_SRC_ALURESULT, im);
    add(o, 1'b1, F_NONE, ALU_SRCA_OLDPC, ALU_SRCB_IMM_EXT, ALU_OP_ADD, RESULT_SRC_ALURESULT, im);
  endtask

  int md_cnt, rw_early, bad;

  initial begin
    reset = 1'b1; op = 7'd0; funct7b1 = 1'b0; mem_ready = 1'b0; md_ready = 1'b0;

    // addi: 4 cycles
    add_fd(OP_ITYPE, IMMSRC_I_TYPE);
    add(OP_ITYPE, 1'b1, F_NONE, ALU_SRCA_RD1, ALU_SRCB_IMM_EXT, ALU_OP_ARITH_LOGIC, RESULT_SRC_ALURESULT, IMMSRC_I_TYPE);
    add(OP_ITYPE, 1'b1, F_RW | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_I_TYPE);
    // add
    add_fd(OP_RTYPE, IMMSRC_R_TYPE);
    add(OP_RTYPE, 1'b1, F_NONE, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ARITH_LOGIC, RESULT_SRC_ALURESULT, IMMSRC_R_TYPE);
    add(OP_RTYPE, 1'b1, F_RW | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_R_TYPE);
    // lw with 3 wait states in FETCH and MEMREAD: 11 cycles
    for (int k = 0; k < 3; k++)
      add(OP_LOAD, 1'b0, F_MV, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_I_TYPE);
    add(OP_LOAD, 1'b1, F_MV | F_IRW | F_PCU, ALU_SRCA_PC, ALU_SRCB_4, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_I_TYPE);
    add(OP_LOAD, 1'b0, F_NONE, ALU_SRCA_OLDPC, ALU_SRCB_IMM_EXT, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_I_TYPE);
    add(OP_LOAD, 1'b0, F_NONE, ALU_SRCA_RD1, ALU_SRCB_IMM_EXT, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_I_TYPE);
    for (int k = 0; k < 3; k++)
      add(OP_LOAD, 1'b0, F_MV | F_ADR, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_I_TYPE);
    add(OP_LOAD, 1'b1, F_MV | F_ADR, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_I_TYPE);
    add(OP_LOAD, 1'b0, F_RW | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_READDATA, IMMSRC_I_TYPE);
    // sw, memory ready at once
    add_fd(OP_STORE, IMMSRC_S_TYPE);
    add(OP_STORE, 1'b1, F_NONE, ALU_SRCA_RD1, ALU_SRCB_IMM_EXT, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_S_TYPE);
    add(OP_STORE, 1'b1, F_MV | F_ADR | F_MW | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_S_TYPE);
    // jal: 3 cycles
    add_fd(OP_JAL, IMMSRC_J_TYPE);
    add(OP_JAL, 1'b1, F_PCU | F_RW | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_PCPLUS4, IMMSRC_J_TYPE);
    // jalr
    add_fd(OP_JALR, IMMSRC_I_TYPE);
    add(OP_JALR, 1'b1, F_PCU | F_RW | F_IC, ALU_SRCA_RD1, ALU_SRCB_IMM_EXT, ALU_OP_ADD, RESULT_SRC_PCPLUS4, IMMSRC_I_TYPE);
    // branch
    add_fd(OP_BRANCH, IMMSRC_B_TYPE);
    add(OP_BRANCH, 1'b1, F_BR | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_BRANCH, RESULT_SRC_ALURESULT, IMMSRC_B_TYPE);
    // lui
    add_fd(OP_LUI, IMMSRC_U_TYPE);
    add(OP_LUI, 1'b1, F_NONE, ALU_SRCA_RD1, ALU_SRCB_IMM_EXT, ALU_OP_LUI, RESULT_SRC_ALURESULT, IMMSRC_U_TYPE);
    add(OP_LUI, 1'b1, F_RW | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_U_TYPE);
    // auipc
    add_fd(OP_AUIPC, IMMSRC_U_TYPE);
    add(OP_AUIPC, 1'b1, F_NONE, ALU_SRCA_OLDPC, ALU_SRCB_IMM_EXT, ALU_OP_AUIPC, RESULT_SRC_ALURESULT, IMMSRC_U_TYPE);
    add(OP_AUIPC, 1'b1, F_RW | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_U_TYPE);
    // csr
    add_fd(OP_SYSTEM, IMMSRC_I_TYPE);
    add(OP_SYSTEM, 1'b1, F_RW | F_IC, ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_CSRDATA, IMMSRC_I_TYPE);

    do_reset();
    foreach (vecs[i]) begin
      op = vecs[i].op; funct7b1 = 1'b0; mem_ready = vecs[i].mr; md_ready = 1'b0;
      #1;
      check($sformatf("vec%0d", i), 32'({fl0, enc(a0, b0, o0, r0, i0)}),
            32'({vecs[i].fl, enc(vecs[i].a, vecs[i].b, vecs[i].aop, vecs[i].rs, vecs[i].imm)}));
      tick();
    end

    // mul: md_ready after 33 cycles; stray md_ready before MULDIV must be ignored
    do_reset();
    op = OP_RTYPE; funct7b1 = 1'b1; mem_ready = 1'b1; md_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    md_cnt = 0; rw_early = 0;
    for (int k = 1; k <= 33; k++) begin
      md_ready = (k == 33);
      #1;
      if (fl0[9]) md_cnt++;
      if (k == 1) check("nomd_illegal_pulse", 32'(fl1), 32'(F_ILL));
      if (k == 33) check("md_writeback", 32'({fl0[4], fl0[2], r0}), 32'({1'b1, 1'b1, RESULT_SRC_MULDIV}));
      else if (fl0[4] || fl0[2]) rw_early++;
      tick();
    end
    md_ready = 1'b0;
    #1;
    check("md_valid_cycles", 32'(md_cnt), 32'd33);
    check("md_no_early_write", 32'(rw_early), 32'd0);
    check("md_valid_drop", 32'(fl0), 32'(F_MV));
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      if (fl1 !== F_HALT ||
          enc(a1, b1, o1, r1, i1) !== enc(ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_R_TYPE))
        bad++;
      tick();
      #1;
    end
    check("nomd_halt_sticky", 32'(bad), 32'd0);
    do_reset();
    #1;
    check("nomd_reset_to_fetch", 32'(fl1), 32'(F_MV));

    // op 0: non-halting variant refetches, default variant halts
    do_reset();
    op = 7'd0; funct7b1 = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    check("ilf_illegal_pulse", 32'(fl2), 32'(F_ILL));
    check("ilf_defaults", 32'(enc(a2, b2, o2, r2, i2)),
          32'(enc(ALU_SRCA_RD1, ALU_SRCB_RD2, ALU_OP_ADD, RESULT_SRC_ALURESULT, IMMSRC_R_TYPE)));
    check("dut_illegal_pulse", 32'(fl0), 32'(F_ILL));
    tick();
    #1;
    check("ilf_refetch", 32'(fl2), 32'(F_MV));
    check("dut_halted", 32'(fl0), 32'(F_HALT));

    // reset during a pending store aborts it immediately
    do_reset();
    op = OP_STORE; mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    check("sw_pending", 32'(fl0), 32'(F_MV | F_ADR | F_MW));
    #1;
    reset = 1'b1;
    #1;
    check("reset_aborts_store", 32'({fl0[10], fl0[3]}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("fetch_after_abort", 32'({fl0[10], fl0[8]}), 32'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
